// File: rtl/maze_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maze_pkg: shared geometry, types and row-wrap helper for the maze    |
// | row prefetch path.                                     Rev 1.0       |
// +----------------------------------------------------------------------+
package maze_pkg;

    localparam int MAZE_WIDTH  = 640;
    localparam int MAZE_HEIGHT = 480;
    localparam int TILE_SHIFT  = 3;
    localparam int MAZE_COLS   = MAZE_WIDTH >> TILE_SHIFT;
    localparam int MAZE_ROWS   = MAZE_HEIGHT >> TILE_SHIFT;

    typedef logic [MAZE_COLS-1:0] maze_row_t;
    typedef logic [5:0]           row_idx_t;

    typedef enum logic [1:0] {
        PRIME = 2'd0,
        IDLE  = 2'd1,
        FETCH = 2'd2
    } fetch_state_e;

    // Row after cur, wrapping the last row (and any blanking row) back to 0.
    function automatic row_idx_t next_row(input row_idx_t cur);
        if (cur >= row_idx_t'(MAZE_ROWS - 1)) begin
            return '0;
        end
        return cur + 6'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/maze_row_fetch_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maze_row_fetch_fsm: req/ack row reader; primes the front buffer and  |
// | captures prefetched rows into the back buffer.         Rev 1.0       |
// +----------------------------------------------------------------------+
module maze_row_fetch_fsm
    import maze_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_trig,
    input  logic                 swap_take,
    input  logic [5:0]           cur_row,
    input  logic                 mem_ack,
    input  logic [MAZE_COLS-1:0] mem_data,
    output logic                 mem_req,
    output logic [5:0]           mem_addr,
    output logic [MAZE_COLS-1:0] back,
    output logic                 back_valid,
    output logic                 prime_load,
    output logic                 priming
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic         w_ack;
    logic         w_req_next;
    logic         w_start_fetch;
    logic         w_capture;
    logic         r_mem_req;
    row_idx_t     r_mem_addr;
    maze_row_t    r_back;
    logic         r_back_valid;

    // An ack only counts against a live request, so a stale pulse is dropped.
    assign w_ack = mem_ack & r_mem_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PRIME:   if (w_ack)      w_state_next = IDLE;
            IDLE:    if (fetch_trig) w_state_next = FETCH;
            FETCH:   if (w_ack)      w_state_next = IDLE;
            default:                 w_state_next = PRIME;
        endcase
    end

    always_comb begin
        w_req_next    = (w_state_next != IDLE);
        w_start_fetch = (r_state == IDLE) && fetch_trig;
        w_capture     = (r_state == FETCH) && w_ack;
        prime_load    = (r_state == PRIME) && w_ack;
        priming       = (r_state == PRIME);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_back       <= '0;
            r_back_valid <= 1'b0;
        end else begin
            r_mem_req <= w_req_next;
            if (w_start_fetch) begin
                r_mem_addr <= next_row(cur_row);
            end
            if (w_capture) begin
                r_back <= mem_data;
            end
            // A capture beats a same-cycle swap: the swap already took the old row.
            if (w_capture) begin
                r_back_valid <= 1'b1;
            end else if (swap_take) begin
                r_back_valid <= 1'b0;
            end
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign back       = r_back;
    assign back_valid = r_back_valid;

endmodule
`default_nettype wire

// File: rtl/maze_row_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | maze_row_prefetch: double-buffered maze row prefetch with registered |
// | per-pixel wall bit. MAZE_UNDERRUN_CNT_EN enables the underrun count. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module maze_row_prefetch
    import maze_pkg::*;
#(
    parameter int WIDTH = MAZE_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           x,
    input  logic [8:0]           y,
    output logic                 mem_req,
    output logic [5:0]           mem_addr,
    input  logic                 mem_ack,
    input  logic [MAZE_COLS-1:0] mem_data,
    output logic                 wall,
    output logic                 row_ready,
    output logic [7:0]           underrun_cnt
);

    localparam logic [9:0] c_x_limit = 10'(WIDTH);

    logic [8:0] r_y_q;
    logic       w_new_line;
    logic       w_fetch_trig;
    logic       w_swap;
    logic       w_swap_take;
    logic       w_prime_load;
    logic       w_priming;
    logic       w_back_valid;
    maze_row_t  w_back;
    maze_row_t  r_front;
    logic       r_wall;
    logic       r_row_ready;

    assign w_new_line   = (y != r_y_q);
    assign w_fetch_trig = w_new_line && (y[TILE_SHIFT-1:0] == '1);
    assign w_swap       = w_new_line && (y[TILE_SHIFT-1:0] == '0) && !w_priming;
    assign w_swap_take  = w_swap && w_back_valid;

    maze_row_fetch_fsm u_fetch (
        .clk        (clk),
        .reset      (reset),
        .fetch_trig (w_fetch_trig),
        .swap_take  (w_swap_take),
        .cur_row    (y[8:TILE_SHIFT]),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .back       (w_back),
        .back_valid (w_back_valid),
        .prime_load (w_prime_load),
        .priming    (w_priming)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y_q       <= '0;
            r_front     <= '0;
            r_row_ready <= 1'b0;
            r_wall      <= 1'b0;
        end else begin
            r_y_q <= y;
            if (w_prime_load) begin
                r_front     <= mem_data;
                r_row_ready <= 1'b1;
            end else if (w_swap_take) begin
                r_front <= w_back;
            end
            // Off-screen columns would index past the row word.
            if (x < c_x_limit) begin
                r_wall <= r_front[x[9:TILE_SHIFT]];
            end else begin
                r_wall <= 1'b0;
            end
        end
    end

`ifdef MAZE_UNDERRUN_CNT_EN
    logic [7:0] r_underrun_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_underrun_cnt <= '0;
        end else if (w_swap && !w_back_valid && (r_underrun_cnt != 8'hFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`else
    assign underrun_cnt = 8'd0;
`endif

    assign wall      = r_wall;
    assign row_ready = r_row_ready;

endmodule
`default_nettype wire

// File: tb/tb_maze_row_prefetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_maze_row_prefetch: randomized scoreboard bench for the maze row   |
// | prefetch block with a behavioural memory and frame model. Rev 1.0    |
// +----------------------------------------------------------------------+
module tb_maze_row_prefetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  x = '0;
    logic [8:0]  y = '0;
    logic        mem_ack = 1'b0;
    logic [79:0] mem_data = '0;
    logic        mem_req;
    logic [5:0]  mem_addr;
    logic        wall;
    logic        row_ready;
    logic [7:0]  underrun_cnt;

    maze_row_prefetch dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .y            (y),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .wall         (wall),
        .row_ready    (row_ready),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wall;
        logic       ready;
        logic       req;
        logic [5:0] addr;
        logic [7:0] under;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [79:0] rows[60];

    // Reference model: what the screen shows and what memory traffic is outstanding.
    logic [79:0] m_front, m_back;
    bit          m_back_full, m_ready, m_priming, m_pending, m_req;
    int          m_addr, m_under, m_last_y, wait_cnt, cur_lat;
    int          lat_fixed = 2;
    int          lat_max = 9;

    function automatic logic [79:0] rand_row();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    function automatic int pick_lat();
        return (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, lat_max));
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_front     = '0;
        m_back      = '0;
        m_back_full = 1'b0;
        m_ready     = 1'b0;
        m_priming   = 1'b1;
        m_pending   = 1'b0;
        m_req       = 1'b0;
        m_addr      = 0;
        m_under     = 0;
        m_last_y    = 0;
        wait_cnt    = 0;
        cur_lat     = pick_lat();
    endtask

    // Called at a negedge: apply one cycle of inputs and predict the next edge.
    task automatic drive(input int nx, input int ny);
        bit   ack, line_chg, tile_end, tile_start;
        exp_t e;
        ack = 1'b0;
        if (m_req) begin
            wait_cnt++;
            ack = (wait_cnt >= cur_lat);
        end
        x        = 10'(nx);
        y        = 9'(ny);
        mem_ack  = ack;
        mem_data = ack ? rows[m_addr] : rand_row();

        e.wall     = (nx < 640) ? m_front[7'(nx / 8)] : 1'b0;
        line_chg   = (ny != m_last_y);
        tile_end   = line_chg && (ny % 8 == 7);
        tile_start = line_chg && (ny % 8 == 0);

        if (tile_start && !m_priming) begin
            if (m_back_full) begin
                m_front     = m_back;
                m_back_full = 1'b0;
            end else if (m_under < 255) begin
                m_under++;
            end
        end
        if (ack) begin
            if (m_priming) begin
                m_front   = rows[m_addr];
                m_ready   = 1'b1;
                m_priming = 1'b0;
            end else begin
                m_back      = rows[m_addr];
                m_back_full = 1'b1;
                m_pending   = 1'b0;
            end
        end else if (!m_priming && !m_pending && tile_end) begin
            m_pending = 1'b1;
            m_addr    = (ny / 8 + 1) % 60;
            wait_cnt  = 0;
            cur_lat   = pick_lat();
        end
        m_req = m_priming || m_pending;

        e.ready = m_ready;
        e.req   = m_req;
        e.addr  = 6'(m_addr);
`ifdef MAZE_UNDERRUN_CNT_EN
        e.under = 8'(m_under);
`else
        e.under = 8'd0;
`endif
        sb.push_back(e);
        m_last_y = ny;
        @(negedge clk);
    endtask

    task automatic run_lines(input int y0, input int y1, input int len);
        for (int ly = y0; ly <= y1; ly++) begin
            for (int c = 0; c < len; c++) begin
                drive(int'($urandom_range(0, 719)), ly % 480);
            end
        end
    endtask

    // Called at a negedge; asserts reset mid-cycle and returns at a negedge after release.
    task automatic do_reset(input bit pulse_ack);
        #2 reset = 1'b1;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 6'd0);
        chk("rst_row_ready", row_ready, 1'b0);
        chk("rst_wall", wall, 1'b0);
        chk("rst_underrun", underrun_cnt, 8'd0);
        if (pulse_ack) begin
            mem_ack  = 1'b1;
            mem_data = rand_row();
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("rst_hold_req", mem_req, 1'b0);
        chk("rst_hold_ready", row_ready, 1'b0);
        x = '0;
        y = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wall", wall, e.wall);
                chk("row_ready", row_ready, e.ready);
                chk("mem_req", mem_req, e.req);
                chk("mem_addr", mem_addr, e.addr);
                chk("underrun_cnt", underrun_cnt, e.under);
            end
        end
    end

    initial begin : stimulus
        for (int r = 0; r < 60; r++) begin
            rows[r] = rand_row();
        end
        rows[0] = 80'h1;
        rows[1] = 80'h2;

        @(negedge clk);
        lat_fixed = 2;
        do_reset(1'b0);

        // Priming, then first-column and second-column probes.
        for (int i = 0; i < 4; i++) drive(0, 0);
        drive(8, 0);
        drive(8, 0);
        drive(0, 0);
        drive(639, 0);
        drive(640, 0);

        lat_fixed = 5;
        run_lines(1, 14, 20);
        // Long-latency fetch of row 2 straddles the 15->16 boundary.
        lat_fixed = 900;
        run_lines(15, 24, 110);

        lat_fixed = 0;
        lat_max   = 14;
        run_lines(25, 490, 12);

        // A fetch that never completes underruns every boundary until saturation.
        lat_fixed = 100000;
        run_lines(0, 2399, 2);

        lat_fixed = 2;
        do_reset(1'b0);
        run_lines(0, 38, 6);
        lat_fixed = 60;
        for (int i = 0; i < 4; i++) drive(int'($urandom_range(0, 639)), 39);
        chk("midfetch_req", mem_req, 1'b1);
        chk("midfetch_addr", mem_addr, 6'd5);
        do_reset(1'b1);

        lat_fixed = 0;
        lat_max   = 9;
        run_lines(0, 40, 10);

        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
